aes_round_key_store: RTL and testbench
======================================

// Module: aes_round_key_store
// PURPOSE
//  Parametrised AES key schedule for 128/192/256-bit keys. Expands one 32-bit word per enabled cycle
//  into an internal round-key buffer of up to 15 x 128 bits.
//  Once the buffer is ready, the cipher/decipher core reads full 128-bit round keys by round index
//  from a random-access port, with no per-word storage logic in the core.
// PARAMETERS
//  MAX_KEY_BITS  256  largest supported key: 128, 192 or 256; sizes buffer to 4*(MAX_KEY_BITS/32+7) words
//  RD_REG        1    1: read data registered (1-cycle latency); 0: combinational read (0-cycle)
// PORTS
//  Clk        in   1    clock
//  Rst        in   1    reset, synchronous, active-high
//  En         in   1    clock enable; low = hold all state (stall), NOT a reset
//  Start      in   1    begin expansion; sampled only in IDLE/READY with En=1
//  KeyLen     in   2    00:128, 01:192, 10:256, 11:illegal
//  KeyIn      in   256  key, MSB-aligned (word0 = [255:224]); latched at Start
//  Busy       out  1    expansion in progress
//  Done       out  1    one-cycle pulse: all round keys written
//  Err        out  1    one-cycle pulse: Start rejected (illegal KeyLen or KeyLen > MAX_KEY_BITS)
//  KeyValid   out  1    buffer holds a complete schedule
//  Nr         out  4    rounds of stored schedule: 10/12/14; 0 when !KeyValid
//  RkRdEn     in   1    round-key read request
//  RkRdIdx    in   4    round index 0..Nr
//  RkRdData   out  128  round key; word 4*idx in [127:96]
//  RkRdValid  out  1    RkRdData valid, aligned with RD_REG latency
// BEHAVIOUR
//  Reset: Busy=Done=Err=KeyValid=RkRdValid=0, Nr=0, RkRdData=0, state IDLE; buffer contents don't-care.
//  States: IDLE -> RUN on legal Start; RUN -> READY after last word; READY -> RUN on legal Start.
//  Start (cycle T, En=1, IDLE/READY, legal):
//    - latch KeyIn and Nk = 4/6/8; Total = 44/52/60
//    - KeyValid=0 and Nr=0 from T+1
//    - Busy=1 from T+1 until the last word is written
//  RUN: word i written in the i-th enabled cycle after Start.
//    - i<Nk: word i = key word i
//    - else w[i] = w[i-Nk] ^ temp, with temp = w[i-1] modified as follows:
//      - i%Nk==0: SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk]; Rcon sequence 01,02,04,...,1b,36
//      - Nk==8 and i%Nk==4: SubWord(w[i-1])
//    - window of last Nk words held internally; no reliance on reading the buffer back
//  Completion: in the enabled cycle after word Total-1 is written:
//    - Done=1 for 1 cycle; KeyValid=1; Nr=Nk+6; Busy=0
//    - Start->Done = Total+1 enabled cycles (45/53/61 with En held high)
//  Start during RUN: ignored (no Err). Start with Done same cycle: impossible (Done only after RUN).
//  Illegal Start: Err=1 for 1 cycle; state, KeyValid and buffer unchanged.
//  En=0 mid-RUN: i, window and Rcon frozen; resumes exactly where stopped.
//    - pulses (Done, Err) never stretched: they are cleared on the next enabled cycle
//  Rst mid-RUN: back to IDLE, KeyValid=0; partial schedule discarded.
//  Read, accepted when RkRdEn=1 and En=1:
//    - RkRdValid=1 only if KeyValid and RkRdIdx<=Nr
//    - otherwise RkRdValid=0 and RkRdData=0
//    - reads during RUN return RkRdValid=0
//    - with RD_REG=1, data and valid appear the next enabled cycle and hold until the next accepted read
// CONFIGURATION
//  AES_RKS_EQINV_EN defined:
//    - adds input Inverse (1 bit), latched at Start
//    - when latched high, round keys 1..Nr-1 are stored as InvMixColumns(rk) (equivalent inverse cipher)
//    - the transform is applied per 32-bit column at buffer write; the expansion window stays untransformed
//    - rk0 and rkNr are stored unmodified
//  AES_RKS_EQINV_EN not defined:
//    - no Inverse port, no InvMixColumns logic
//    - buffer always holds the forward schedule
// TESTING
//  128: KeyIn[255:128]=2b7e151628aed2a6abf7158809cf4f3c, Start
//    -> Done at cycle 45; rd idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; Nr=10
//  192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//    -> Done at 53; rd idx12 -> e98ba06f448c773c8ecc720401002202
//  256: key 603deb10...0914dff4 (FIPS-197 A.3)
//    -> Done at 61; rd idx14 -> fe4890d1e6188d0b046df344706c631e
//  Stall/robustness:
//    - En toggled 1/0 randomly during 128 run -> identical rk10 as above; Done after 45 enabled cycles
//    - Rst at word 20 -> KeyValid=0, rd idx0 -> RkRdValid=0
//  Rejects: MAX_KEY_BITS=128 with KeyLen=10 -> Err pulse, KeyValid unchanged; rd idx11 on 128 schedule -> RkRdValid=0
//  EQINV_EN, Inverse=1, 128 key above:
//    - rd idx9 -> InvMixColumns(ac7766f319fadc2128d12941575c006e)
//    - rd idx0/10 match the forward schedule

Source files
------------

// File: rtl/aes_round_key_store.sv
// AES key schedule (128/192/256-bit keys) with a random-access round-key buffer.
// One schedule word is expanded per enabled cycle. The cipher core then reads
// complete 128-bit round keys by round index.
// Optional feature: define AES_RKS_EQINV_EN to add the Inverse input. When Inverse
// is latched high, round keys 1..Nr-1 are stored as InvMixColumns(rk), which is
// the layout the equivalent inverse cipher expects.
module aes_round_key_store #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RD_REG       = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic         Start,
  input  logic [1:0]   KeyLen,
  input  logic [255:0] KeyIn,
`ifdef AES_RKS_EQINV_EN
  input  logic         Inverse,
`endif
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic         KeyValid,
  output logic [3:0]   Nr,
  input  logic         RkRdEn,
  input  logic [3:0]   RkRdIdx,
  output logic [127:0] RkRdData,
  output logic         RkRdValid
);

  localparam int ROWS = MAX_KEY_BITS / 32 + 7;

  typedef enum logic [1:0] {IDLE, RUN, FIN, READY} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t               state;
  logic [255:0]         key_sr;   // latched key, shifted out one word per RUN cycle
  logic [7:0][31:0]     win;      // last 8 schedule words, win[7] = newest
  logic [5:0]           idx;      // index of the word being produced
  logic [2:0]           ph;       // idx mod Nk
  logic [3:0]           nk;
  logic [7:0]           rcon;
  logic [3:0][31:0]     rk_mem [0:ROWS-1];

  logic                 legal;
  logic [3:0]           nk_sel;
  logic [5:0]           last_idx;
  logic [31:0]          w_prev;
  logic [31:0]          w_back;
  logic [31:0]          sub_in;
  logic [31:0]          sub_out;
  logic [31:0]          w_new;
  logic [31:0]          w_store;
  logic                 rd_ok;

  assign last_idx = {nk, 2'b00} + 6'd27;  // 4*(Nk+7) - 1
  assign rd_ok    = KeyValid && (RkRdIdx <= Nr);

  // Decode the requested key length and check it against the build limit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    legal  = 1'b0;
    nk_sel = 4'd4;
    case (KeyLen)
      2'b00:   begin legal = 1'b1;                 nk_sel = 4'd4; end
      2'b01:   begin legal = (MAX_KEY_BITS >= 192); nk_sel = 4'd6; end
      2'b10:   begin legal = (MAX_KEY_BITS >= 256); nk_sel = 4'd8; end
      default: begin legal = 1'b0;                 nk_sel = 4'd4; end
    endcase
  end

  // Next schedule word from the sliding window.
  always_comb begin
    w_prev = win[7];
    case (nk)
      4'd4:    w_back = win[4];
      4'd6:    w_back = win[2];
      default: w_back = win[0];
    endcase
    sub_in  = (ph == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (idx < {2'b00, nk})
      w_new = key_sr[255:224];
    else if (ph == 3'd0)
      w_new = w_back ^ sub_out ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && ph == 3'd4)
      w_new = w_back ^ sub_out;
    else
      w_new = w_back ^ w_prev;
  end

`ifdef AES_RKS_EQINV_EN
  logic inv_q;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Middle round keys are transformed on their way into the buffer; the window stays forward.
  always_comb begin
    if (inv_q && idx >= 6'd4 && idx < last_idx - 6'd3)
      w_store = inv_mix_col(w_new);
    else
      w_store = w_new;
  end
`else
  assign w_store = w_new;
`endif

  // Control FSM, expansion datapath and status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      KeyValid <= 1'b0;
      Nr       <= 4'd0;
      key_sr   <= '0;
      win      <= '0;
      idx      <= 6'd0;
      ph       <= 3'd0;
      nk       <= 4'd4;
      rcon     <= 8'h01;
`ifdef AES_RKS_EQINV_EN
      inv_q    <= 1'b0;
`endif
    end else if (En) begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (Start) begin
            if (legal) begin
              state    <= RUN;
              Busy     <= 1'b1;
              KeyValid <= 1'b0;
              Nr       <= 4'd0;
              key_sr   <= KeyIn;
              idx      <= 6'd0;
              ph       <= 3'd0;
              nk       <= nk_sel;
              rcon     <= 8'h01;
`ifdef AES_RKS_EQINV_EN
              inv_q    <= Inverse;
`endif
            end else begin
              Err <= 1'b1;
            end
          end
        end
        RUN: begin
          key_sr <= {key_sr[223:0], 32'h0};
          win    <= {w_new, win[7:1]};
          idx    <= idx + 6'd1;
          ph     <= ({1'b0, ph} == nk - 4'd1) ? 3'd0 : ph + 3'd1;
          if (idx >= {2'b00, nk} && ph == 3'd0) rcon <= xtime(rcon);
          if (idx == last_idx) state <= FIN;
        end
        FIN: begin
          state    <= READY;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          KeyValid <= 1'b1;
          Nr       <= nk + 4'd6;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key buffer write, one 32-bit column per RUN cycle.
  // NOTE: the buffer has no reset; KeyValid gates every read of it.
  always_ff @(posedge Clk) begin
    if (En && state == RUN) rk_mem[idx[5:2]][~idx[1:0]] <= w_store;
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      // Registered read port; result holds until the next accepted read.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          RkRdData  <= '0;
          RkRdValid <= 1'b0;
        end else if (En && RkRdEn) begin
          RkRdValid <= rd_ok;
          RkRdData  <= rd_ok ? rk_mem[RkRdIdx] : '0;
        end
      end
    end else begin : g_rd_comb
      assign RkRdValid = RkRdEn && En && rd_ok;
      assign RkRdData  = RkRdValid ? rk_mem[RkRdIdx] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store: FIPS-197 key schedules, stalls, resets,
// rejected starts and both read-port latencies.
`timescale 1ns/1ps
module tb_aes_round_key_store;

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK9_128  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst, en, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, err, key_valid;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         rd_valid;

  logic         b_rst, b_en, b_start;
  logic [1:0]   b_key_len;
  logic [255:0] b_key_in;
  logic         b_busy, b_done, b_err, b_key_valid;
  logic [3:0]   b_nr;
  logic         b_rd_en;
  logic [3:0]   b_rd_idx;
  logic [127:0] b_rd_data;
  logic         b_rd_valid;

`ifdef AES_RKS_EQINV_EN
  logic         inverse;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  aes_round_key_store #(.MAX_KEY_BITS(256), .RD_REG(1)) dut (
    .Clk(clk), .Rst(rst), .En(en), .Start(start), .KeyLen(key_len), .KeyIn(key_in),
`ifdef AES_RKS_EQINV_EN
    .Inverse(inverse),
`endif
    .Busy(busy), .Done(done), .Err(err), .KeyValid(key_valid), .Nr(nr),
    .RkRdEn(rd_en), .RkRdIdx(rd_idx), .RkRdData(rd_data), .RkRdValid(rd_valid)
  );

  aes_round_key_store #(.MAX_KEY_BITS(128), .RD_REG(0)) dut128 (
    .Clk(clk), .Rst(b_rst), .En(b_en), .Start(b_start), .KeyLen(b_key_len), .KeyIn(b_key_in),
`ifdef AES_RKS_EQINV_EN
    .Inverse(1'b0),
`endif
    .Busy(b_busy), .Done(b_done), .Err(b_err), .KeyValid(b_key_valid), .Nr(b_nr),
    .RkRdEn(b_rd_en), .RkRdIdx(b_rd_idx), .RkRdData(b_rd_data), .RkRdValid(b_rd_valid)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [1:0] len, input logic [255:0] key);
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    en      = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Step until Done, counting enabled cycles since the Start edge; bounded.
  task automatic run_to_done(input int first, output int cycles);
    cycles = first;
    while (!done && cycles < 500) begin
      step();
      cycles++;
    end
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    step();
    rd_en  = 1'b0;
  endtask

`ifdef AES_RKS_EQINV_EN
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] m_inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      r[127 - 32*c -: 32] = {
        m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09),
        m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d),
        m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b),
        m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e)};
    end
    return r;
  endfunction
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0;
    rd_en = 1'b0; rd_idx = 4'd0;
    b_rst = 1'b1; b_en = 1'b1; b_start = 1'b0; b_key_len = 2'b00; b_key_in = '0;
    b_rd_en = 1'b0; b_rd_idx = 4'd0;
`ifdef AES_RKS_EQINV_EN
    inverse = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_key_valid", 128'(key_valid), 128'd0);
    check("rst_nr", 128'(nr), 128'd0);
    check("rst_rd_valid", 128'(rd_valid), 128'd0);
    check("rst_rd_data", rd_data, 128'd0);

    // AES-128 schedule
    start_key(2'b00, {K128, 128'h0});
    check("k128_busy_after_start", 128'(busy), 128'd1);
    check("k128_kv_after_start", 128'(key_valid), 128'd0);
    run_to_done(0, n);
    check("k128_done_latency", 128'(n), 128'd45);
    check("k128_kv", 128'(key_valid), 128'd1);
    check("k128_nr", 128'(nr), 128'd10);
    check("k128_busy_done", 128'(busy), 128'd0);
    step();
    check("k128_done_pulse", 128'(done), 128'd0);
    rd(4'd10);
    check("k128_rk10_valid", 128'(rd_valid), 128'd1);
    check("k128_rk10", rd_data, RK10_128);
    rd(4'd0);
    check("k128_rk0", rd_data, K128);
    rd(4'd1);
    check("k128_rk1", rd_data, RK1_128);
    rd(4'd9);
    check("k128_rk9", rd_data, RK9_128);
    step();
    check("k128_rd_hold_valid", 128'(rd_valid), 128'd1);
    check("k128_rd_hold_data", rd_data, RK9_128);
    rd(4'd11);
    check("k128_idx11_valid", 128'(rd_valid), 128'd0);
    check("k128_idx11_data", rd_data, 128'd0);

    // Illegal KeyLen rejected, schedule untouched
    start_key(2'b11, {K192, 64'h0});
    check("illegal_err", 128'(err), 128'd1);
    check("illegal_kv", 128'(key_valid), 128'd1);
    check("illegal_busy", 128'(busy), 128'd0);
    step();
    check("illegal_err_pulse", 128'(err), 128'd0);
    rd(4'd10);
    check("illegal_rk10_kept", rd_data, RK10_128);

    // AES-192 schedule with a read attempted during RUN
    start_key(2'b01, {K192, 64'h0});
    rd(4'd0);
    check("k192_run_rd_valid", 128'(rd_valid), 128'd0);
    check("k192_run_rd_data", rd_data, 128'd0);
    run_to_done(1, n);
    check("k192_done_latency", 128'(n), 128'd53);
    check("k192_nr", 128'(nr), 128'd12);
    rd(4'd12);
    check("k192_rk12", rd_data, RK12_192);
    rd(4'd0);
    check("k192_rk0", rd_data, K192[191:64]);

    // AES-256 schedule with an extra Start during RUN (ignored)
    start_key(2'b10, K256);
    repeat (10) step();
    key_len = 2'b00;
    start   = 1'b1;
    step();
    start   = 1'b0;
    check("k256_run_start_err", 128'(err), 128'd0);
    check("k256_run_start_busy", 128'(busy), 128'd1);
    run_to_done(11, n);
    check("k256_done_latency", 128'(n), 128'd61);
    check("k256_nr", 128'(nr), 128'd14);
    rd(4'd14);
    check("k256_rk14", rd_data, RK14_256);
    rd(4'd1);
    check("k256_rk1", rd_data, K256[127:0]);

    // AES-128 with random En stalls
    start_key(2'b00, {K128, 128'h0});
    n = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      en = 1'($urandom_range(0, 1));
      step();
      if (en) n++;
    end
    en = 1'b1;
    check("stall_enabled_cycles", 128'(n), 128'd45);
    rd(4'd10);
    check("stall_rk10", rd_data, RK10_128);

    // Reset in the middle of an expansion
    start_key(2'b00, {K128, 128'h0});
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_kv", 128'(key_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_nr", 128'(nr), 128'd0);
    rd(4'd0);
    check("midrst_rd_valid", 128'(rd_valid), 128'd0);

`ifdef AES_RKS_EQINV_EN
    // Equivalent inverse cipher layout
    inverse = 1'b1;
    start_key(2'b00, {K128, 128'h0});
    inverse = 1'b0;
    run_to_done(0, n);
    check("eqinv_done_latency", 128'(n), 128'd45);
    rd(4'd9);
    check("eqinv_rk9", rd_data, m_inv_mix(RK9_128));
    rd(4'd0);
    check("eqinv_rk0", rd_data, K128);
    rd(4'd10);
    check("eqinv_rk10", rd_data, RK10_128);
`endif

    // 128-bit build with combinational read port
    b_key_len = 2'b00;
    b_key_in  = {K128, 128'h0};
    b_start   = 1'b1;
    step();
    b_start   = 1'b0;
    repeat (45) step();
    check("b_done_at_45", 128'(b_done), 128'd1);
    check("b_nr", 128'(b_nr), 128'd10);
    b_rd_en  = 1'b1;
    b_rd_idx = 4'd10;
    #1;
    check("b_comb_rk10_valid", 128'(b_rd_valid), 128'd1);
    check("b_comb_rk10", b_rd_data, RK10_128);
    b_rd_idx = 4'd11;
    #1;
    check("b_comb_idx11_valid", 128'(b_rd_valid), 128'd0);
    check("b_comb_idx11_data", b_rd_data, 128'd0);
    b_rd_en = 1'b0;
    b_key_len = 2'b10;
    b_start   = 1'b1;
    step();
    b_start   = 1'b0;
    check("b_256_rejected_err", 128'(b_err), 128'd1);
    check("b_256_rejected_kv", 128'(b_key_valid), 128'd1);
    check("b_256_rejected_busy", 128'(b_busy), 128'd0);
    step();
    check("b_err_pulse", 128'(b_err), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
